// File: rtl/vga_fb_arbiter_if.sv
// Draw-engine write port into the framebuffer arbiter: valid/ready handshake
// carrying a cell coordinate and its RGB444 colour.
interface vga_fb_arbiter_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_x;
  logic [6:0]  wr_y;
  logic [11:0] wr_data;

  modport master (output wr_valid, wr_x, wr_y, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_x, wr_y, wr_data, output wr_ready);
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: fixed scan-out read slots in the visible
// area, draw writes fill every other RAM cycle; also drives the pixel stream.
module vga_fb_arbiter #(
  parameter int FB_W = 160,
  parameter int FB_H = 120
) (
  input  logic            vga_clk,
  input  logic            rst_n,
  input  logic [9:0]      countX,
  input  logic [9:0]      countY,
  vga_fb_arbiter_if.slave wr,
  output logic [14:0]     ram_addr,
  output logic            ram_we,
  output logic [11:0]     ram_wdata,
  input  logic [11:0]     ram_rdata,
  output logic [11:0]     pix_rgb,
  output logic            pix_valid,
  output logic            vblank_start,
  output logic [15:0]     stall_cnt,
  output logic            range_err
);

  localparam logic [0:0]  S_IDLE = 1'b0;
  localparam logic [0:0]  S_PEND = 1'b1;
  localparam int          PIPE   = 3;
  localparam logic [14:0] FB_W15 = 15'(FB_W);

  typedef struct packed {
    logic [14:0] addr;
    logic [11:0] data;
  } wr_req_t;

  logic        act, rd_slot, wr_in_range, wr_take;
  logic [14:0] rd_addr, wr_addr;

  logic [0:0]  state_q, state_d;
  wr_req_t     req_q, req_d;
  logic [14:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [11:0] wdata_q, wdata_d;
  logic [15:0] stall_q, stall_d;
  logic        rerr_q, rerr_d;
  logic [PIPE:1] vld_pipe_q;
  logic [2:1]  slot_pipe_q;
  logic [11:0] pix_q;
  logic        vblank_q;

  assign act     = (countX < 10'd640) && (countY < 10'd480);
  assign rd_slot = act && (countX[1:0] == 2'b00);
  assign rd_addr = 15'(countY[9:2]) * FB_W15 + 15'(countX[9:2]);
  assign wr_addr = 15'(wr.wr_y) * FB_W15 + 15'(wr.wr_x);

  assign wr_in_range = (int'(wr.wr_x) < FB_W) && (int'(wr.wr_y) < FB_H);
  assign wr.wr_ready = (state_q == S_IDLE);
  assign wr_take     = wr.wr_valid && wr.wr_ready;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    stall_d = stall_q;
    rerr_d  = rerr_q;
    // Read slot owns the port; a pending write waits for the next free cycle.
    if (rd_slot) begin
      addr_d = rd_addr;
      if (state_q == S_PEND && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    end else if (state_q == S_PEND) begin
      addr_d  = req_q.addr;
      we_d    = 1'b1;
      wdata_d = req_q.data;
      state_d = S_IDLE;
    end
    // Out-of-range writes complete the handshake but never reach the RAM.
    if (wr_take) begin
      if (wr_in_range) begin
        state_d = S_PEND;
        req_d   = '{addr: wr_addr, data: wr.wr_data};
      end else begin
        rerr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      stall_q     <= '0;
      rerr_q      <= 1'b0;
      vld_pipe_q  <= '0;
      slot_pipe_q <= '0;
      pix_q       <= '0;
      vblank_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      stall_q     <= stall_d;
      rerr_q      <= rerr_d;
      vld_pipe_q  <= {vld_pipe_q[PIPE-1:1], act};
      slot_pipe_q <= {slot_pipe_q[1], rd_slot};
      // slot_pipe_q[2] marks the cycle the slot's RAM data is on ram_rdata.
      if (slot_pipe_q[2]) pix_q <= ram_rdata;
      vblank_q    <= (countX == 10'd0) && (countY == 10'd480);
    end
  end

  assign ram_addr     = addr_q;
  assign ram_we       = we_q;
  assign ram_wdata    = wdata_q;
  assign pix_valid    = vld_pipe_q[PIPE];
  assign pix_rgb      = vld_pipe_q[PIPE] ? pix_q : 12'h000;
  assign vblank_start = vblank_q;
  assign stall_cnt    = stall_q;
  assign range_err    = rerr_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: address table, hand-written corner sequences and a
// randomized run against a look-ahead schedule model with a shadow framebuffer.
module tb_vga_fb_arbiter;
  localparam int NR = 3000;
  localparam int NP = NR + 16;

  logic        vga_clk = 1'b0;
  logic        rst_n;
  logic [9:0]  countX, countY;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [11:0] ram_wdata, ram_rdata, pix_rgb;
  logic        pix_valid, vblank_start, range_err;
  logic [15:0] stall_cnt;

  vga_fb_arbiter_if wr();

  vga_fb_arbiter #(.FB_W(160), .FB_H(120)) dut (
    .vga_clk(vga_clk), .rst_n(rst_n), .countX(countX), .countY(countY), .wr(wr),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .pix_rgb(pix_rgb), .pix_valid(pix_valid), .vblank_start(vblank_start),
    .stall_cnt(stall_cnt), .range_err(range_err)
  );

  always #5 vga_clk = ~vga_clk;

  // Synchronous single-port RAM, read-before-write, with bench preload hooks.
  logic [11:0] ram [0:32767];
  logic        pl_all = 1'b0, pl_one = 1'b0;
  logic [14:0] pl_addr = '0;
  logic [11:0] pl_data = '0;
  int          pl_seed = 0;

  function automatic logic [11:0] init_f(input int a, input int s);
    logic [31:0] h;
    h = (32'(a) * 32'h9E3779B1) ^ 32'(s);
    return h[23:12];
  endfunction

  always @(posedge vga_clk) begin
    if (pl_all) begin
      for (int a = 0; a < 32768; a++) ram[a] <= init_f(a, pl_seed);
    end else if (pl_one) ram[pl_addr] <= pl_data;
    else if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  int errs = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  task automatic tick;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic drv(input int x, input int y, input logic v, input int wx, input int wy, input int wd);
    countX = 10'(x); countY = 10'(y);
    wr.wr_valid = v; wr.wr_x = 8'(wx); wr.wr_y = 7'(wy); wr.wr_data = 12'(wd);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    drv(0, 0, 1'b0, 0, 0, 0);
    #2;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic preload(input int a, input int d);
    rst_n = 1'b0;
    pl_one = 1'b1; pl_addr = 15'(a); pl_data = 12'(d);
    tick;
    pl_one = 1'b0;
  endtask

  // ---------------- address table ----------------
  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [14:0] addr;
    logic        vb;
  } vec_t;

  task automatic run_table;
    vec_t tv[12];
    tv[0]  = '{10'd20,   10'd8,    15'd325,   1'b0};
    tv[1]  = '{10'd21,   10'd8,    15'd325,   1'b0};
    tv[2]  = '{10'd0,    10'd0,    15'd0,     1'b0};
    tv[3]  = '{10'd636,  10'd476,  15'd19199, 1'b0};
    tv[4]  = '{10'd640,  10'd0,    15'd19199, 1'b0};
    tv[5]  = '{10'd0,    10'd480,  15'd19199, 1'b1};
    tv[6]  = '{10'd4,    10'd479,  15'd19041, 1'b0};
    tv[7]  = '{10'd1023, 10'd1023, 15'd19041, 1'b0};
    tv[8]  = '{10'd639,  10'd479,  15'd19041, 1'b0};
    tv[9]  = '{10'd0,    10'd479,  15'd19040, 1'b0};
    tv[10] = '{10'd0,    10'd481,  15'd19040, 1'b0};
    tv[11] = '{10'd320,  10'd240,  15'd9680,  1'b0};
    for (int i = 0; i < 12; i++) begin
      drv(int'(tv[i].x), int'(tv[i].y), 1'b0, 0, 0, 0);
      tick;
      chk("tbl ram_addr", 32'(ram_addr), 32'(tv[i].addr));
      chk("tbl ram_we", 32'(ram_we), 32'd0);
      chk("tbl vblank", 32'(vblank_start), 32'(tv[i].vb));
    end
  endtask

  // ---------------- hand sequences ----------------
  task automatic seq_pixel;
    preload(325, 'hABC);
    do_reset;
    for (int i = 0; i < 9; i++) begin
      drv(i < 4 ? 20 + i : 640, 8, 1'b0, 0, 0, 0);
      tick;
      if (i == 0) begin
        chk("pix addr", 32'(ram_addr), 32'd325);
        chk("pix we", 32'(ram_we), 32'd0);
      end
      if (i + 1 >= 3 && i + 1 <= 6) begin
        chk("pix rgb", 32'(pix_rgb), 32'hABC);
        chk("pix valid", 32'(pix_valid), 32'd1);
      end else begin
        chk("pix rgb blank", 32'(pix_rgb), 32'd0);
        chk("pix valid blank", 32'(pix_valid), 32'd0);
      end
    end
  endtask

  task automatic seq_write;
    do_reset;
    drv(0, 0, 1'b0, 0, 0, 0); tick;
    drv(1, 0, 1'b0, 0, 0, 0); tick;
    drv(2, 0, 1'b1, 10, 3, 'h123);
    chk("wr ready idle", 32'(wr.wr_ready), 32'd1);
    tick;
    drv(3, 0, 1'b0, 0, 0, 0);
    chk("wr ready pend", 32'(wr.wr_ready), 32'd0);
    tick;
    drv(4, 0, 1'b0, 0, 0, 0);
    chk("wr we", 32'(ram_we), 32'd1);
    chk("wr addr", 32'(ram_addr), 32'd490);
    chk("wr data", 32'(ram_wdata), 32'h123);
    chk("wr ready back", 32'(wr.wr_ready), 32'd1);
    tick;
    chk("wr we drop", 32'(ram_we), 32'd0);
    chk("wr stall", 32'(stall_cnt), 32'd0);
  endtask

  task automatic seq_stall;
    preload(1, 'h3C9);
    do_reset;
    for (int i = 0; i < 3; i++) begin
      drv(i, 0, 1'b0, 0, 0, 0); tick;
    end
    drv(3, 0, 1'b1, 7, 1, 'h7E5); tick;
    drv(4, 0, 1'b0, 0, 0, 0);
    chk("stl ready c4", 32'(wr.wr_ready), 32'd0);
    chk("stl cnt c4", 32'(stall_cnt), 32'd0);
    tick;
    drv(5, 0, 1'b0, 0, 0, 0);
    chk("stl read addr", 32'(ram_addr), 32'd1);
    chk("stl read we", 32'(ram_we), 32'd0);
    chk("stl cnt c5", 32'(stall_cnt), 32'd1);
    chk("stl ready c5", 32'(wr.wr_ready), 32'd0);
    tick;
    drv(6, 0, 1'b0, 0, 0, 0);
    chk("stl we", 32'(ram_we), 32'd1);
    chk("stl addr", 32'(ram_addr), 32'd167);
    chk("stl data", 32'(ram_wdata), 32'h7E5);
    chk("stl ready c6", 32'(wr.wr_ready), 32'd1);
    tick;
    drv(7, 0, 1'b0, 0, 0, 0);
    chk("stl addr hold", 32'(ram_addr), 32'd167);
    chk("stl pix", 32'(pix_rgb), 32'h3C9);
    chk("stl cnt c7", 32'(stall_cnt), 32'd1);
  endtask

  task automatic seq_range;
    do_reset;
    drv(700, 0, 1'b1, 160, 5, 'hFFF);
    chk("rng ready", 32'(wr.wr_ready), 32'd1);
    chk("rng err pre", 32'(range_err), 32'd0);
    tick;
    drv(700, 0, 1'b0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("rng ready after", 32'(wr.wr_ready), 32'd1);
      chk("rng err sticky", 32'(range_err), 32'd1);
      chk("rng no we", 32'(ram_we), 32'd0);
      tick;
    end
    rst_n = 1'b0;
    #1;
    chk("rng err reset", 32'(range_err), 32'd0);
    // A write captured just before reset must never reach the RAM.
    rst_n = 1'b1;
    drv(700, 0, 1'b1, 1, 1, 'hFFF);
    tick;
    drv(700, 0, 1'b0, 0, 0, 0);
    chk("lost pend", 32'(wr.wr_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("lost ready", 32'(wr.wr_ready), 32'd1);
    chk("lost addr", 32'(ram_addr), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("lost no we", 32'(ram_we), 32'd0);
    end
  endtask

  task automatic seq_b2b;
    int vb;
    vb = 0;
    do_reset;
    for (int i = 0; i < 12; i++) begin
      drv(i, 480, 1'b1, i, 0, i);
      chk("b2b ready", 32'(wr.wr_ready), 32'(i % 2 == 0));
      chk("b2b we", 32'(ram_we), 32'(i >= 2 && i % 2 == 0));
      if (i >= 2 && i % 2 == 0) begin
        chk("b2b addr", 32'(ram_addr), 32'(i - 2));
        chk("b2b data", 32'(ram_wdata), 32'(i - 2));
      end
      vb += int'(vblank_start);
      tick;
    end
    chk("b2b vblank pulses", 32'(vb), 32'd1);
  endtask

  // ---------------- randomized run vs look-ahead model ----------------
  logic [9:0]  cx [NP];
  logic [9:0]  cy [NP];
  logic        e_we [NP];
  logic [14:0] e_addr [NP];
  logic [11:0] e_wd [NP];
  logic        e_rdy [NP];
  logic        e_vb [NP];
  int          e_stinc [NP];
  logic [11:0] rdval [NP];
  logic        w_s [NP];
  logic [14:0] w_a [NP];
  logic [11:0] w_d [NP];
  logic [11:0] mfb [0:19199];

  function automatic logic act_f(input logic [9:0] x, input logic [9:0] y);
    return (int'(x) < 640) && (int'(y) < 480);
  endfunction

  function automatic logic slot_f(input logic [9:0] x, input logic [9:0] y);
    return act_f(x, y) && (int'(x) % 4 == 0);
  endfunction

  function automatic logic [14:0] rdaddr_f(input logic [9:0] x, input logic [9:0] y);
    return 15'((int'(y) / 4) * 160 + int'(x) / 4);
  endfunction

  task automatic run_random;
    int t, len, d, wx, wy, wd, stall_exp, rerr_at, r;
    logic [9:0]  x0, y0;
    logic [11:0] hold;
    logic        v, pv;
    // Counts: runs of incrementing X at random start points, mixed with blanking.
    t = 0;
    while (t < NP) begin
      len = 4 + int'($urandom % 40);
      x0 = ($urandom % 4 == 0) ? 10'($urandom) : 10'($urandom % 640);
      r = int'($urandom % 8);
      y0 = (r < 5) ? 10'($urandom % 480) : (r == 5) ? 10'd480 : 10'($urandom);
      for (int j = 0; j < len && t < NP; j++) begin
        cx[t] = x0 + 10'(j); cy[t] = y0; t++;
      end
    end
    for (int i = 0; i < NP; i++) begin
      e_we[i] = 0; e_addr[i] = '0; e_wd[i] = '0; e_rdy[i] = 1; e_vb[i] = 0;
      e_stinc[i] = 0; rdval[i] = '0; w_s[i] = 0; w_a[i] = '0; w_d[i] = '0;
    end
    rst_n = 1'b0;
    pl_seed = int'($urandom);
    pl_all = 1'b1;
    tick;
    pl_all = 1'b0;
    for (int a = 0; a < 19200; a++) mfb[a] = init_f(a, pl_seed);
    do_reset;
    rerr_at = NP + 100;
    stall_exp = 0;
    hold = '0;
    for (int c = 0; c < NR; c++) begin
      if (c >= 3 && slot_f(cx[c-3], cy[c-3])) hold = rdval[c-3];
      pv = (c >= 3) && act_f(cx[c-3], cy[c-3]);
      stall_exp += e_stinc[c];
      chk("rnd ram_we", 32'(ram_we), 32'(e_we[c]));
      chk("rnd ram_addr", 32'(ram_addr), 32'(e_addr[c]));
      chk("rnd ram_wdata", 32'(ram_wdata), 32'(e_wd[c]));
      chk("rnd wr_ready", 32'(wr.wr_ready), 32'(e_rdy[c]));
      chk("rnd vblank", 32'(vblank_start), 32'(e_vb[c]));
      chk("rnd pix_valid", 32'(pix_valid), 32'(pv));
      chk("rnd pix_rgb", 32'(pix_rgb), pv ? 32'(hold) : 32'd0);
      chk("rnd stall_cnt", 32'(stall_cnt), 32'(stall_exp));
      chk("rnd range_err", 32'(range_err), 32'(c >= rerr_at));

      v  = ($urandom % 3) != 0;
      wx = ($urandom % 64 == 0) ? 160 + int'($urandom % 96) : int'($urandom % 160);
      wy = ($urandom % 64 == 0) ? 120 + int'($urandom % 8) : int'($urandom % 120);
      wd = int'($urandom % 4096);
      drv(int'(cx[c]), int'(cy[c]), v, wx, wy, wd);

      if (w_s[c]) mfb[w_a[c]] = w_d[c];
      if (slot_f(cx[c], cy[c])) begin
        rdval[c] = mfb[rdaddr_f(cx[c], cy[c])];
        e_addr[c+1] = rdaddr_f(cx[c], cy[c]);
        e_wd[c+1] = e_wd[c];
      end else if (!e_we[c+1]) begin
        e_addr[c+1] = e_addr[c];
        e_wd[c+1] = e_wd[c];
      end
      e_vb[c+1] = (cx[c] == 10'd0) && (cy[c] == 10'd480);
      if (v && e_rdy[c]) begin
        if (wx < 160 && wy < 120) begin
          // Write goes out on the first non-slot cycle after capture.
          d = c + 1;
          while (d < NP - 2 && slot_f(cx[d], cy[d])) begin
            e_stinc[d+1]++;
            d++;
          end
          for (int j = c + 1; j <= d; j++) e_rdy[j] = 0;
          e_we[d+1] = 1; e_addr[d+1] = 15'(wy * 160 + wx); e_wd[d+1] = 12'(wd);
          w_s[d+1] = 1; w_a[d+1] = 15'(wy * 160 + wx); w_d[d+1] = 12'(wd);
        end else if (rerr_at > c + 1) begin
          rerr_at = c + 1;
        end
      end
      tick;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drv(0, 0, 1'b0, 0, 0, 0);
    tick;
    tick;
    chk("rst ram_addr", 32'(ram_addr), 32'd0);
    chk("rst ram_we", 32'(ram_we), 32'd0);
    chk("rst ram_wdata", 32'(ram_wdata), 32'd0);
    chk("rst pix_rgb", 32'(pix_rgb), 32'd0);
    chk("rst pix_valid", 32'(pix_valid), 32'd0);
    chk("rst vblank", 32'(vblank_start), 32'd0);
    chk("rst stall", 32'(stall_cnt), 32'd0);
    chk("rst range_err", 32'(range_err), 32'd0);
    chk("rst wr_ready", 32'(wr.wr_ready), 32'd1);
    rst_n = 1'b1;
    run_table;
    seq_pixel;
    seq_write;
    seq_stall;
    seq_range;
    seq_b2b;
    run_random;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
